// File: rtl/cl_ocl_regfile_pkg.sv
// Shared definitions for the OCL register-file slave: AXI response codes,
// the write/read FSM state encodings and a byte-swap helper for the
// optional big-endian read view.
package cl_ocl_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_GOT_A = 2'd1,
        W_GOT_D = 2'd2,
        W_RESP  = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    // Reverse byte order of a 32-bit word.
    function automatic logic [31:0] byte_swap32(input logic [31:0] value);
        return {value[7:0], value[15:8], value[23:16], value[31:24]};
    endfunction

endpackage

// File: rtl/cl_sync2.sv
// Two-flop synchroniser of parametrised width. Used both for the virtual
// DIP bus and, with d tied high, as the reset deassertion synchroniser
// (assertion stays asynchronous through rst_n).
module cl_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture; the first stage may go metastable, the second settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cl_ocl_regfile.sv
// AXI4-Lite register file on the OCL path. NUM_REGS 32-bit registers with
// byte-strobe writes, optional read-only and byte-swapped views, SLVERR for
// unmapped accesses, and a virtual LED output gated by synchronised DIPs.
// Write and read channels run independent state machines.
module cl_ocl_regfile
    import cl_ocl_regfile_pkg::*;
#(
    parameter int          NUM_REGS     = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0500,
    parameter logic [63:0] RO_MASK      = 64'h0,
    parameter logic [63:0] SWAP_MASK    = 64'h1,
    parameter int          VLED_IDX     = 1,
    parameter logic [31:0] UNIMPL_VALUE = 32'hDEAF_BEEF,
    parameter bit          SLVERR_EN    = 1'b1
) (
    input  logic                     clk_main_a0,
    input  logic                     rst_main_n,

    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              awaddr,

    input  logic                     wvalid,
    output logic                     wready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,

    output logic                     bvalid,
    input  logic                     bready,
    output logic [1:0]               bresp,

    input  logic                     arvalid,
    output logic                     arready,
    input  logic [31:0]              araddr,

    output logic                     rvalid,
    input  logic                     rready,
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,

    input  logic [32*NUM_REGS-1:0]   ro_value,
    output logic [32*NUM_REGS-1:0]   rw_value,

    input  logic [15:0]              sh_cl_status_vdip,
    output logic [15:0]              cl_sh_status_vled
);

    localparam int                  IDX_W     = $clog2(NUM_REGS);
    localparam logic [NUM_REGS-1:0] RO_BITS   = RO_MASK[NUM_REGS-1:0];
    localparam logic [NUM_REGS-1:0] SWAP_BITS = SWAP_MASK[NUM_REGS-1:0];
    localparam logic [1:0]          UNMAPPED_RESP = SLVERR_EN ? RESP_SLVERR : RESP_OKAY;

    // Parameter sanity: refuse to elaborate a register file that cannot
    // honour its own index parameters.
    if (NUM_REGS < 2 || NUM_REGS > 64) begin : g_bad_num_regs
        $error("cl_ocl_regfile: NUM_REGS must be within 2..64");
    end
    if (VLED_IDX < 0 || VLED_IDX >= NUM_REGS) begin : g_bad_vled_idx
        $error("cl_ocl_regfile: VLED_IDX must be below NUM_REGS");
    end
    if (NUM_REGS < 64) begin : g_mask_range
        if ((RO_MASK >> NUM_REGS) != 64'h0 || (SWAP_MASK >> NUM_REGS) != 64'h0) begin : g_bad_mask
            $error("cl_ocl_regfile: RO_MASK/SWAP_MASK select registers beyond NUM_REGS");
        end
    end

    // ------------------------------------------------------------------
    // Reset and DIP synchronisation
    // ------------------------------------------------------------------
    logic        rst_sync_n;
    logic [15:0] vdip_sync;

    cl_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_rst_sync (
        .clk   (clk_main_a0),
        .rst_n (rst_main_n),
        .d     (1'b1),
        .q     (rst_sync_n)
    );

    cl_sync2 #(
        .WIDTH     (16),
        .RESET_VAL (16'h0000)
    ) u_vdip_sync (
        .clk   (clk_main_a0),
        .rst_n (rst_sync_n),
        .d     (sh_cl_status_vdip),
        .q     (vdip_sync)
    );

    // ------------------------------------------------------------------
    // Register storage and flat views
    // ------------------------------------------------------------------
    logic [31:0] regs   [NUM_REGS];
    logic [31:0] ro_arr [NUM_REGS];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign rw_value[32*g +: 32] = regs[g];
        assign ro_arr[g]            = ro_value[32*g +: 32];
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t   wr_state;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q;

    logic        aw_hs;
    logic        w_hs;
    logic        wr_commit;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] wr_off;
    logic        wr_hit;
    logic [IDX_W-1:0] wr_idx;

    // Ready flags follow the FSM but stay low until the synchronised reset releases.
    always_comb begin
        awready = rst_sync_n && (wr_state == W_IDLE || wr_state == W_GOT_D);
        wready  = rst_sync_n && (wr_state == W_IDLE || wr_state == W_GOT_A);
    end

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign bvalid = (wr_state == W_RESP);
    assign bresp  = bresp_q;

    // Pick the address/data pair that commits this edge: live bus values for
    // the half arriving now, latched values for the half that arrived earlier.
    always_comb begin
        wr_commit = 1'b0;
        wr_addr   = aw_addr_q;
        wr_data   = w_data_q;
        wr_strb   = w_strb_q;
        case (wr_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_commit = 1'b1;
                    wr_addr   = awaddr;
                    wr_data   = wdata;
                    wr_strb   = wstrb;
                end
            end
            W_GOT_A: begin
                if (w_hs) begin
                    wr_commit = 1'b1;
                    wr_data   = wdata;
                    wr_strb   = wstrb;
                end
            end
            W_GOT_D: begin
                if (aw_hs) begin
                    wr_commit = 1'b1;
                    wr_addr   = awaddr;
                end
            end
            default: begin
                wr_commit = 1'b0;
            end
        endcase
    end

    // Decode the committing address: aligned, at or above the base, inside the file.
    always_comb begin
        wr_off = wr_addr - BASE_ADDR;
        wr_hit = (wr_addr >= BASE_ADDR) && (wr_off[1:0] == 2'b00) &&
                 ((wr_off >> 2) < 32'(NUM_REGS));
        wr_idx = wr_off[IDX_W+1:2];
    end

    // Write FSM: collect AW and W in either order, then hold the response until bready.
    always_ff @(posedge clk_main_a0 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            wr_state  <= W_IDLE;
            aw_addr_q <= 32'h0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (wr_commit) begin
                wr_state <= W_RESP;
                bresp_q  <= wr_hit ? RESP_OKAY : UNMAPPED_RESP;
            end else begin
                case (wr_state)
                    W_IDLE: begin
                        if (aw_hs) begin
                            wr_state  <= W_GOT_A;
                            aw_addr_q <= awaddr;
                        end else if (w_hs) begin
                            wr_state <= W_GOT_D;
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                        end
                    end
                    W_RESP: begin
                        if (bready) begin
                            wr_state <= W_IDLE;
                            bresp_q  <= RESP_OKAY;
                        end
                    end
                    default: begin
                        wr_state <= wr_state;
                    end
                endcase
            end
        end
    end

    // Register file update: byte-granular, skipped for unmapped or read-only targets.
    always_ff @(posedge clk_main_a0 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= 32'h0;
            end
        end else if (wr_commit && wr_hit) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (IDX_W'(r) == wr_idx && !RO_BITS[r]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) begin
                            regs[r][8*b +: 8] <= wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t   rd_state;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        ar_hs;
    logic [31:0] ar_off;
    logic        ar_hit;
    logic [IDX_W-1:0] ar_idx;
    logic [31:0] rd_value;

    assign arready = rst_sync_n && (rd_state == R_IDLE);
    assign ar_hs   = arvalid && arready;
    assign rvalid  = (rd_state == R_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    // Decode the read address with the same rules as the write side.
    always_comb begin
        ar_off = araddr - BASE_ADDR;
        ar_hit = (araddr >= BASE_ADDR) && (ar_off[1:0] == 2'b00) &&
                 ((ar_off >> 2) < 32'(NUM_REGS));
        ar_idx = ar_off[IDX_W+1:2];
    end

    // Select the read value from pre-edge register state; swap is applied last.
    always_comb begin
        rd_value = UNIMPL_VALUE;
        if (ar_hit) begin
            rd_value = RO_BITS[ar_idx] ? ro_arr[ar_idx] : regs[ar_idx];
            if (SWAP_BITS[ar_idx]) begin
                rd_value = byte_swap32(rd_value);
            end
        end
    end

    // Read FSM: capture on the AR handshake, hold data until rready, then clear.
    always_ff @(posedge clk_main_a0 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            rd_state <= R_IDLE;
            rdata_q  <= 32'h0;
            rresp_q  <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state <= R_RESP;
                        rdata_q  <= rd_value;
                        rresp_q  <= ar_hit ? RESP_OKAY : UNMAPPED_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rd_state <= R_IDLE;
                        rdata_q  <= 32'h0;
                        rresp_q  <= RESP_OKAY;
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Virtual LEDs
    // ------------------------------------------------------------------

    // LEDs mirror the low half of the selected register, gated by the DIPs.
    always_ff @(posedge clk_main_a0 or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            cl_sh_status_vled <= 16'h0000;
        end else begin
            cl_sh_status_vled <= regs[VLED_IDX][15:0] & vdip_sync;
        end
    end

endmodule

// File: tb/tb_cl_ocl_regfile.sv
// Directed bench for cl_ocl_regfile. Two instances share all inputs: dut0
// uses SLVERR_EN=1 with register 2 read-only, dut1 uses SLVERR_EN=0 so the
// unmapped-response variants are observed on the same stimulus.
module tb_cl_ocl_regfile;

    localparam int N = 8;

    logic clk_main_a0;
    logic rst_main_n;

    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic [15:0] sh_cl_status_vdip;
    logic [32*N-1:0] ro_value;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [32*N-1:0] rw_value;
    logic [15:0] cl_sh_status_vled;

    logic        n_awready, n_wready, n_bvalid, n_arready, n_rvalid;
    logic [1:0]  n_bresp, n_rresp;
    logic [31:0] n_rdata;
    logic [32*N-1:0] n_rw_value;
    logic [15:0] n_vled;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_regs [N];

    cl_ocl_regfile #(
        .NUM_REGS (N), .BASE_ADDR (32'h0000_0500), .RO_MASK (64'h4),
        .SWAP_MASK (64'h1), .VLED_IDX (1), .UNIMPL_VALUE (32'hDEAF_BEEF), .SLVERR_EN (1'b1)
    ) dut0 (
        .clk_main_a0 (clk_main_a0), .rst_main_n (rst_main_n),
        .awvalid (awvalid), .awready (awready), .awaddr (awaddr),
        .wvalid (wvalid), .wready (wready), .wdata (wdata), .wstrb (wstrb),
        .bvalid (bvalid), .bready (bready), .bresp (bresp),
        .arvalid (arvalid), .arready (arready), .araddr (araddr),
        .rvalid (rvalid), .rready (rready), .rdata (rdata), .rresp (rresp),
        .ro_value (ro_value), .rw_value (rw_value),
        .sh_cl_status_vdip (sh_cl_status_vdip), .cl_sh_status_vled (cl_sh_status_vled)
    );

    cl_ocl_regfile #(
        .NUM_REGS (N), .BASE_ADDR (32'h0000_0500), .RO_MASK (64'h4),
        .SWAP_MASK (64'h1), .VLED_IDX (1), .UNIMPL_VALUE (32'hDEAF_BEEF), .SLVERR_EN (1'b0)
    ) dut1 (
        .clk_main_a0 (clk_main_a0), .rst_main_n (rst_main_n),
        .awvalid (awvalid), .awready (n_awready), .awaddr (awaddr),
        .wvalid (wvalid), .wready (n_wready), .wdata (wdata), .wstrb (wstrb),
        .bvalid (n_bvalid), .bready (bready), .bresp (n_bresp),
        .arvalid (arvalid), .arready (n_arready), .araddr (araddr),
        .rvalid (n_rvalid), .rready (rready), .rdata (n_rdata), .rresp (n_rresp),
        .ro_value (ro_value), .rw_value (n_rw_value),
        .sh_cl_status_vdip (sh_cl_status_vdip), .cl_sh_status_vled (n_vled)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk_main_a0 = 1'b0;
        forever #5 clk_main_a0 = ~clk_main_a0;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < N; i++) begin
            check_output($sformatf("%s_reg%0d", tag, i), 64'(rw_value[32*i +: 32]), 64'(exp_regs[i]));
            check_output($sformatf("%s_nreg%0d", tag, i), 64'(n_rw_value[32*i +: 32]), 64'(exp_regs[i]));
        end
    endtask

    // Full write with AW and W together; returns both instances' responses.
    task automatic apply_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic [1:0] n_resp);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk_main_a0);
            n++;
        end
        check_output("wr_accept", 64'(n < 20), 64'd1);
        @(negedge clk_main_a0);
        awvalid = 1'b0; wvalid = 1'b0;
        check_output("wr_bvalid", 64'(bvalid), 64'd1);
        resp = bresp; n_resp = n_bresp;
        bready = 1'b1;
        @(negedge clk_main_a0);
        bready = 1'b0;
    endtask

    // Full read; rvalid must appear one cycle after the AR handshake.
    task automatic apply_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                              output logic [31:0] n_data, output logic [1:0] n_resp);
        int n;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk_main_a0);
            n++;
        end
        check_output("rd_accept", 64'(n < 20), 64'd1);
        @(negedge clk_main_a0);
        arvalid = 1'b0;
        check_output("rd_latency", 64'(rvalid), 64'd1);
        data = rdata; resp = rresp; n_data = n_rdata; n_resp = n_rresp;
        rready = 1'b1;
        @(negedge clk_main_a0);
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d, nd;
        logic [1:0]  r, nr;

        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        sh_cl_status_vdip = 16'hFFFF;
        ro_value = '0;
        ro_value[95:64] = 32'hCAFE_0002;
        for (int i = 0; i < N; i++) exp_regs[i] = 32'h0;
        rst_main_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_main_a0);
        check_output("rst_awready", 64'(awready), 64'd0);
        check_output("rst_wready", 64'(wready), 64'd0);
        check_output("rst_arready", 64'(arready), 64'd0);
        check_output("rst_bvalid", 64'(bvalid), 64'd0);
        check_output("rst_rvalid", 64'(rvalid), 64'd0);
        check_output("rst_rdata", 64'(rdata), 64'd0);
        check_output("rst_vled", 64'(cl_sh_status_vled), 64'd0);
        rst_main_n = 1'b1;
        repeat (3) @(negedge clk_main_a0);
        check_output("post_rst_awready", 64'(awready), 64'd1);
        apply_read(32'h500, d, r, nd, nr);
        check_output("rd0_data", 64'(d), 64'h0);
        check_output("rd0_resp", 64'(r), 64'h0);
        check_regs("rst");

        // Full write then swapped read
        apply_write(32'h500, 32'h1234_5678, 4'hF, r, nr);
        check_output("wr0_resp", 64'(r), 64'h0);
        exp_regs[0] = 32'h1234_5678;
        apply_read(32'h500, d, r, nd, nr);
        check_output("rd0_swap", 64'(d), 64'h7856_3412);
        check_regs("wr0");

        // W three cycles ahead of AW, partial strobe
        wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
        check_output("wfirst_wready", 64'(wready), 64'd1);
        @(negedge clk_main_a0);
        wvalid = 1'b0;
        check_output("gotd_wready", 64'(wready), 64'd0);
        check_output("gotd_awready", 64'(awready), 64'd1);
        check_output("gotd_bvalid", 64'(bvalid), 64'd0);
        repeat (2) @(negedge clk_main_a0);
        awaddr = 32'h504; awvalid = 1'b1;
        @(negedge clk_main_a0);
        awvalid = 1'b0;
        check_output("late_aw_bvalid", 64'(bvalid), 64'd1);
        check_output("late_aw_bresp", 64'(bresp), 64'd0);
        bready = 1'b1;
        @(negedge clk_main_a0);
        bready = 1'b0;
        check_output("late_aw_bdone", 64'(bvalid), 64'd0);
        exp_regs[1] = 32'h00BB_00DD;
        check_regs("strb");
        check_output("vled_ffff", 64'(cl_sh_status_vled), 64'h00DD);
        sh_cl_status_vdip = 16'hFFF0;
        repeat (4) @(negedge clk_main_a0);
        check_output("vled_fff0", 64'(cl_sh_status_vled), 64'h00D0);
        sh_cl_status_vdip = 16'hFFFF;
        repeat (4) @(negedge clk_main_a0);

        // Unmapped and read-only accesses
        apply_read(32'h5FC, d, r, nd, nr);
        check_output("unm_rdata", 64'(d), 64'hDEAF_BEEF);
        check_output("unm_rresp", 64'(r), 64'h2);
        check_output("unm_n_rdata", 64'(nd), 64'hDEAF_BEEF);
        check_output("unm_n_rresp", 64'(nr), 64'h0);
        apply_read(32'h4FC, d, r, nd, nr);
        check_output("below_rresp", 64'(r), 64'h2);
        apply_read(32'h520, d, r, nd, nr);
        check_output("past_end_rresp", 64'(r), 64'h2);
        apply_read(32'h51C, d, r, nd, nr);
        check_output("last_reg_rresp", 64'(r), 64'h0);
        check_output("last_reg_rdata", 64'(d), 64'h0);
        apply_write(32'h502, 32'hFFFF_FFFF, 4'hF, r, nr);
        check_output("misal_bresp", 64'(r), 64'h2);
        check_output("misal_n_bresp", 64'(nr), 64'h0);
        apply_write(32'h520, 32'hFFFF_FFFF, 4'hF, r, nr);
        check_output("past_end_bresp", 64'(r), 64'h2);
        apply_write(32'h508, 32'h1111_1111, 4'hF, r, nr);
        check_output("ro_bresp", 64'(r), 64'h0);
        check_regs("unm");
        apply_read(32'h508, d, r, nd, nr);
        check_output("ro_rdata", 64'(d), 64'hCAFE_0002);
        apply_read(32'h504, d, r, nd, nr);
        check_output("reg1_rdata", 64'(d), 64'h00BB_00DD);

        // Write response backpressure
        awaddr = 32'h50C; wdata = 32'hA5A5_5A5A; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        check_output("bp_w_ready", 64'(awready && wready), 64'd1);
        @(negedge clk_main_a0);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_output("bp_bvalid", 64'(bvalid), 64'd1);
            check_output("bp_bresp", 64'(bresp), 64'd0);
            check_output("bp_awready", 64'(awready), 64'd0);
            @(negedge clk_main_a0);
        end
        bready = 1'b1;
        @(negedge clk_main_a0);
        bready = 1'b0;
        check_output("bp_bdone", 64'(bvalid), 64'd0);
        check_output("bp_awready_back", 64'(awready), 64'd1);
        exp_regs[3] = 32'hA5A5_5A5A;

        // Read response backpressure
        araddr = 32'h50C; arvalid = 1'b1;
        check_output("bp_arready", 64'(arready), 64'd1);
        @(negedge clk_main_a0);
        arvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_output("bp_rvalid", 64'(rvalid), 64'd1);
            check_output("bp_rdata", 64'(rdata), 64'hA5A5_5A5A);
            check_output("bp_arready_low", 64'(arready), 64'd0);
            @(negedge clk_main_a0);
        end
        rready = 1'b1;
        @(negedge clk_main_a0);
        rready = 1'b0;
        check_output("bp_rdone", 64'(rvalid), 64'd0);
        check_output("bp_rdata_clr", 64'(rdata), 64'd0);
        check_output("bp_arready_back", 64'(arready), 64'd1);

        // Same-edge write and read of one register: read sees old value
        awaddr = 32'h504; wdata = 32'h1111_2222; wstrb = 4'hF; araddr = 32'h504;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk_main_a0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_output("same_edge_rdata", 64'(rdata), 64'h00BB_00DD);
        check_output("same_edge_bvalid", 64'(bvalid), 64'd1);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk_main_a0);
        bready = 1'b0; rready = 1'b0;
        exp_regs[1] = 32'h1111_2222;
        apply_read(32'h504, d, r, nd, nr);
        check_output("after_same_edge", 64'(d), 64'h1111_2222);
        check_regs("bp");

        // Reset asserted while the write FSM holds only an address
        awaddr = 32'h500; awvalid = 1'b1;
        @(negedge clk_main_a0);
        awvalid = 1'b0;
        check_output("gota_wready", 64'(wready), 64'd1);
        check_output("gota_awready", 64'(awready), 64'd0);
        #1 rst_main_n = 1'b0;
        #1;
        check_output("mid_rst_wready", 64'(wready), 64'd0);
        check_output("mid_rst_awready", 64'(awready), 64'd0);
        check_output("mid_rst_vled", 64'(cl_sh_status_vled), 64'd0);
        for (int i = 0; i < N; i++) exp_regs[i] = 32'h0;
        @(negedge clk_main_a0);
        check_regs("wrst");
        rst_main_n = 1'b1;
        repeat (3) @(negedge clk_main_a0);
        check_output("wrst_bvalid", 64'(bvalid), 64'd0);

        // Reset asserted while a read response is pending
        apply_write(32'h504, 32'h0000_00FF, 4'hF, r, nr);
        araddr = 32'h504; arvalid = 1'b1;
        @(negedge clk_main_a0);
        arvalid = 1'b0;
        check_output("rresp_pending", 64'(rdata), 64'h0000_00FF);
        #1 rst_main_n = 1'b0;
        #1;
        check_output("rrst_rvalid", 64'(rvalid), 64'd0);
        check_output("rrst_rdata", 64'(rdata), 64'd0);
        check_output("rrst_arready", 64'(arready), 64'd0);
        @(negedge clk_main_a0);
        rst_main_n = 1'b1;
        repeat (3) @(negedge clk_main_a0);
        apply_write(32'h500, 32'hABCD_0123, 4'hF, r, nr);
        check_output("fresh_bresp", 64'(r), 64'h0);
        apply_read(32'h500, d, r, nd, nr);
        check_output("fresh_rdata", 64'(d), 64'h2301_CDAB);
        exp_regs[0] = 32'hABCD_0123;
        check_regs("fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
